host_reg_slave: RTL and testbench
=================================

Name: host_reg_slave

Overview:
- Parametrised register-bank target for the host bus (sel/wr/addr/wdata/rdata).
- Extends the fixed 4-bit-address / 8-bit-data host protocol with:
  - configurable address and data widths;
  - programmable wait states with a ready handshake;
  - error response;
  - read-only registers;
  - hardware-side register update ports.
- Sits between the host agent's interface and DUT control logic; exposes every register in parallel to the core.

Parameters:
- ADDR_W, 4: host address width.
- DATA_W, 8: register and data-bus width.
- NUM_REGS, 12: implemented registers, 1..2**ADDR_W; addresses >= NUM_REGS are unmapped.
- WAIT_CYCLES, 2: wait states inserted before ready, 0..15.
- RO_MASK, 12'h800 (NUM_REGS bits): bit i set marks register i read-only to the host.
- RESET_VAL, 8'h00 (DATA_W bits): reset value of every register.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- sel_i  in  1  access request; held high by the master until ready_o.
- wr_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_W  register address.
- wdata_i  in  DATA_W  write data.
- rdata_o  out  DATA_W  read data; valid only while ready_o = 1.
- ready_o  out  1  one-cycle access-complete pulse.
- err_o  out  1  error flag; valid only with ready_o.
- regs_o  out  NUM_REGS*DATA_W  current register contents; register i at bits [i*DATA_W +: DATA_W].
- hw_we_i  in  NUM_REGS  per-register hardware write enable.
- hw_wdata_i  in  NUM_REGS*DATA_W  hardware write data, same packing as regs_o.

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - state = IDLE; all registers = RESET_VAL.
  - ready_o = 0, err_o = 0, rdata_o = 0.
  - Assertion mid-access aborts the access: no write, no ready.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: sel_i = 1 at a rising edge captures wr_i, addr_i, wdata_i into holding registers. Go to WAIT with counter = WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES = 0.
  - WAIT: decrement counter; go to RESP when counter = 0.
  - RESP: ready_o = 1 for exactly one cycle, then IDLE.
- Abort: sel_i = 0 while in WAIT returns the FSM to IDLE next edge. No write, no ready_o, no err_o.
- Latency: sel_i sampled at edge N gives ready_o high in cycle N+1+WAIT_CYCLES.
- Back-to-back: a new access can be captured from IDLE the edge after RESP, so throughput is one access per WAIT_CYCLES+2 cycles.
- Read:
  - Registered rdata_o = register[addr] during RESP, 0 in all other cycles.
  - Unmapped address: rdata_o = 0, err_o = 1.
- Write:
  - Commits at the edge ending RESP; regs_o reflects the new value the following cycle.
  - Unmapped address or RO_MASK bit set: no write, err_o = 1.
- err_o is 0 whenever ready_o is 0.
- Hardware update:
  - hw_we_i[i] = 1 loads hw_wdata_i slice into register i at that edge. Applies in any state and regardless of RO_MASK.
  - Same-edge collision with a committing host write to the same register: host write wins.
  - Hardware writes to other registers proceed unaffected.
- Captured fields are used for the whole access; wr_i/addr_i/wdata_i changes after capture are ignored.
- WAIT_CYCLES wrap: counter width is 4 bits; values above 15 are illegal (elaboration assertion).

Decomposition:
- Shared package host_reg_pkg:
  - state enum (IDLE, WAIT, RESP);
  - wait-counter width constant;
  - function computing the register-index width from NUM_REGS.
- One sub-module: host_reg_bank, containing register storage, write arbitration (host over hw) and RO masking.
- The top holds the FSM, capture registers and response logic.

Test Plan (default parameters):
1. Reset then read addr 3 → ready_o at cycle 4 after sel sample; rdata_o = 8'h00; err_o = 0.
2. Write addr 5 = 8'hA5, then read addr 5 → ready on both accesses; rdata_o = 8'hA5; regs_o[47:40] = 8'hA5.
3. Write addr 11 (RO) = 8'h3C → err_o = 1 with ready_o; register 11 unchanged. Read addr 14 (unmapped) → rdata_o = 0, err_o = 1.
4. hw_we_i[5] = 1 with hw_wdata_i slice 8'h11 on the same edge as a host write of 8'h22 to addr 5 → register 5 = 8'h22. Next cycle hw_we_i[5] with 8'h11 → register 5 = 8'h11.
5. Drop sel_i one cycle into WAIT of a write to addr 2 → no ready_o; register 2 unchanged. Next access completes normally.
6. Assert rst_ni low during WAIT of a write to addr 4 = 8'hFF → outputs 0 immediately; register 4 = 8'h00 after release. Rerun tests 1–2 with WAIT_CYCLES = 0 → ready at cycle 2.

Source files
------------

// File: rtl/host_reg_pkg.sv
// host_reg_pkg: shared FSM encoding, wait-counter width and index-width helper for host_reg_slave.
package host_reg_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;
   localparam int CNT_W = 4;
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/host_reg_bank.sv
// host_reg_bank: register storage with host-over-hardware write priority and read-only masking.
module host_reg_bank
   import host_reg_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_REGS = 12,
   parameter int IDX_W = 4,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         host_we_i,
   input  logic [IDX_W-1:0]             host_idx_i,
   input  logic [DATA_W-1:0]            host_wdata_i,
   input  logic [NUM_REGS-1:0]          hw_we_i,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata_i,
   output logic                         ro_o,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o
);
   // Indices past NUM_REGS shift out of the mask and read as writable; the top flags them unmapped.
   assign ro_o = |(RO_MASK & (NUM_REGS'(1) << host_idx_i));
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic [DATA_W-1:0] r_val;
      logic              w_host_hit;
      assign w_host_hit = host_we_i && host_idx_i == IDX_W'(i) && !RO_MASK[i];
      always_ff @(posedge clk_i or negedge rst_ni)
         if (!rst_ni) r_val <= RESET_VAL;
         else if (w_host_hit) r_val <= host_wdata_i;
         else if (hw_we_i[i]) r_val <= hw_wdata_i[i*DATA_W +: DATA_W];
      assign regs_o[i*DATA_W +: DATA_W] = r_val;
   end
endmodule

// File: rtl/host_reg_slave.sv
// host_reg_slave: host-bus register target with wait states, ready/error response and
// parallel register exposure plus hardware-side update ports.
module host_reg_slave
   import host_reg_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int NUM_REGS = 12,
   parameter int WAIT_CYCLES = 2,
   parameter logic [NUM_REGS-1:0] RO_MASK = 12'h800,
   parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         sel_i,
   input  logic                         wr_i,
   input  logic [ADDR_W-1:0]            addr_i,
   input  logic [DATA_W-1:0]            wdata_i,
   output logic [DATA_W-1:0]            rdata_o,
   output logic                         ready_o,
   output logic                         err_o,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   input  logic [NUM_REGS-1:0]          hw_we_i,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata_i
);
   localparam int IDX_W = idx_width(NUM_REGS);
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("host_reg_slave: WAIT_CYCLES must be 0..15");
   end
   if (NUM_REGS < 1 || NUM_REGS > 2**ADDR_W) begin : g_bad_regs
      $error("host_reg_slave: NUM_REGS must be 1..2**ADDR_W");
   end
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_wr;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic               w_mapped;
   logic               w_ro;
   logic               w_err;
   logic [ADDR_W-1:0]  w_rd_addr;
   logic               w_rd_wr;
   logic               w_to_resp;
   logic [DATA_W-1:0]  w_rd_data;
   assign w_mapped = 32'(r_addr) < NUM_REGS;
   assign w_err    = !w_mapped || (r_wr && w_ro);
   assign ready_o  = r_state == ST_RESP;
   assign err_o    = ready_o && w_err;
   assign rdata_o  = r_rdata;
   // With zero wait states RESP follows IDLE directly, so read data comes from the live bus.
   always_comb begin
      w_rd_addr = (r_state == ST_IDLE) ? addr_i : r_addr;
      w_rd_wr   = (r_state == ST_IDLE) ? wr_i : r_wr;
      w_to_resp = (r_state == ST_IDLE) ? (sel_i && WAIT_CYCLES == 0)
                                       : (r_state == ST_WAIT && sel_i && r_cnt == '0);
      w_rd_data = (32'(w_rd_addr) < NUM_REGS) ? regs_o[32'(w_rd_addr)*DATA_W +: DATA_W] : '0;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_rdata <= (w_to_resp && !w_rd_wr) ? w_rd_data : '0;
         if (r_state == ST_IDLE && sel_i) begin
            r_wr    <= wr_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_cnt   <= CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
         end else if (r_state == ST_WAIT) begin
            r_cnt   <= r_cnt - 1'b1;
            r_state <= !sel_i ? ST_IDLE : (r_cnt == '0 ? ST_RESP : ST_WAIT);
         end else if (r_state == ST_RESP) begin
            r_state <= ST_IDLE;
         end
      end
   host_reg_bank #(
      .DATA_W(DATA_W),
      .NUM_REGS(NUM_REGS),
      .IDX_W(IDX_W),
      .RO_MASK(RO_MASK),
      .RESET_VAL(RESET_VAL)
   ) u_bank (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .host_we_i(ready_o && r_wr && w_mapped),
      .host_idx_i(r_addr[IDX_W-1:0]),
      .host_wdata_i(r_wdata),
      .hw_we_i(hw_we_i),
      .hw_wdata_i(hw_wdata_i),
      .ro_o(w_ro),
      .regs_o(regs_o)
   );
endmodule

// File: tb/tb_host_reg_slave.sv
// tb_host_reg_slave: directed self-checking bench for host_reg_slave (WAIT_CYCLES = 2 and 0).
module tb_host_reg_slave;
   logic        clk = 0, rst_n = 0, sel = 0, sel0 = 0, wr = 0;
   logic [3:0]  addr = 0;
   logic [7:0]  wdata = 0;
   logic [11:0] hw_we = 0;
   logic [95:0] hw_wdata = 0;
   logic [7:0]  rdata, rdata0;
   logic        ready, ready0, err, err0;
   logic [95:0] regs, regs0;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   host_reg_slave dut (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata), .ready_o(ready), .err_o(err), .regs_o(regs),
      .hw_we_i(hw_we), .hw_wdata_i(hw_wdata)
   );

   host_reg_slave #(.WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel0), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata0), .ready_o(ready0), .err_o(err0), .regs_o(regs0),
      .hw_we_i(hw_we), .hw_wdata_i(hw_wdata)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   // Returns in the RESP cycle's data, then steps one edge past RESP (back in IDLE).
   task automatic access(input bit z, input bit w, input logic [3:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic e, output int lat, output logic ra);
      @(negedge clk);
      wr = w; addr = a; wdata = d;
      if (z) sel0 = 1; else sel = 1;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!(z ? ready0 : ready) && lat < 20);
      rd = z ? rdata0 : rdata;
      e  = z ? err0 : err;
      sel = 0; sel0 = 0;
      @(posedge clk); #1;
      ra = z ? ready0 : ready;
   endtask

   task automatic test_reset();
      rst_n = 0;
      #12;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
      n_checks++; if (regs !== 96'h0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", regs); end
      n_checks++; if (regs0 !== 96'h0) begin n_fail++; $display("FAIL reset_regs0: got %h expected 0", regs0); end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_read_reset_value();
      logic [7:0] rd; logic e, ra; int lat;
      access(0, 0, 4'd3, 8'h00, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read3_latency: got %0d expected 3", lat); end
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL read3_rdata: got %h expected 00", rd); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL read3_err: got %b expected 0", e); end
      n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL read3_ready_pulse: got %b expected 0", ra); end
      n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL read3_rdata_idle: got %h expected 00", rdata); end
   endtask

   task automatic test_write_read();
      logic [7:0] rd; logic e, ra; int lat;
      access(0, 1, 4'd5, 8'hA5, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr5_latency: got %0d expected 3", lat); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr5_err: got %b expected 0", e); end
      n_checks++; if (regs[47:40] !== 8'hA5) begin n_fail++; $display("FAIL wr5_regs: got %h expected a5", regs[47:40]); end
      access(0, 0, 4'd5, 8'h00, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd5_latency: got %0d expected 3", lat); end
      n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd5_rdata: got %h expected a5", rd); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd5_err: got %b expected 0", e); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd; logic e, ra; int lat;
      access(0, 1, 4'd8, 8'h81, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_wr8_latency: got %0d expected 3", lat); end
      access(0, 1, 4'd9, 8'h92, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_wr9_latency: got %0d expected 3", lat); end
      access(0, 0, 4'd8, 8'h00, rd, e, lat, ra);
      n_checks++; if (rd !== 8'h81) begin n_fail++; $display("FAIL b2b_rd8_rdata: got %h expected 81", rd); end
      n_checks++; if (regs[79:72] !== 8'h92) begin n_fail++; $display("FAIL b2b_reg9: got %h expected 92", regs[79:72]); end
   endtask

   task automatic test_errors();
      logic [7:0] rd; logic e, ra; int lat;
      access(0, 1, 4'd11, 8'h3C, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ro11_latency: got %0d expected 3", lat); end
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ro11_err: got %b expected 1", e); end
      n_checks++; if (regs[95:88] !== 8'h00) begin n_fail++; $display("FAIL ro11_reg: got %h expected 00", regs[95:88]); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ro11_err_after: got %b expected 0", err); end
      access(0, 0, 4'd14, 8'h00, rd, e, lat, ra);
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL unmapped14_rdata: got %h expected 00", rd); end
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped14_err: got %b expected 1", e); end
      access(0, 1, 4'd13, 8'h77, rd, e, lat, ra);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmapped13_wr_err: got %b expected 1", e); end
   endtask

   task automatic test_hw_collision();
      int lat;
      @(negedge clk);
      sel = 1; wr = 1; addr = 4'd5; wdata = 8'h22;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!ready && lat < 20);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL coll_latency: got %0d expected 3", lat); end
      hw_we = 12'h8A0;
      hw_wdata = '0;
      hw_wdata[47:40] = 8'h11;
      hw_wdata[63:56] = 8'h77;
      hw_wdata[95:88] = 8'h5A;
      sel = 0;
      @(posedge clk); #1;
      n_checks++; if (regs[47:40] !== 8'h22) begin n_fail++; $display("FAIL coll_host_wins: got %h expected 22", regs[47:40]); end
      n_checks++; if (regs[63:56] !== 8'h77) begin n_fail++; $display("FAIL coll_hw_reg7: got %h expected 77", regs[63:56]); end
      n_checks++; if (regs[95:88] !== 8'h5A) begin n_fail++; $display("FAIL coll_hw_ro11: got %h expected 5a", regs[95:88]); end
      hw_we = 12'h020;
      @(posedge clk); #1;
      n_checks++; if (regs[47:40] !== 8'h11) begin n_fail++; $display("FAIL hw_reg5: got %h expected 11", regs[47:40]); end
      hw_we = '0;
   endtask

   task automatic test_abort();
      logic [7:0] rd; logic e, ra; int lat; logic seen;
      @(negedge clk);
      sel = 1; wr = 1; addr = 4'd2; wdata = 8'h99;
      @(posedge clk); #1;
      @(negedge clk); sel = 0;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ready || err) seen = 1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b expected 0", seen); end
      n_checks++; if (regs[23:16] !== 8'h00) begin n_fail++; $display("FAIL abort_reg2: got %h expected 00", regs[23:16]); end
      access(0, 0, 4'd2, 8'h00, rd, e, lat, ra);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 3", lat); end
      n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL abort_next_rdata: got %h expected 00", rd); end
   endtask

   task automatic test_capture_hold();
      int lat;
      @(negedge clk);
      sel = 1; wr = 1; addr = 4'd6; wdata = 8'h66;
      @(posedge clk); #1;
      lat = 1;
      wr = 0; addr = 4'd14; wdata = 8'h00;
      while (!ready && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL hold_latency: got %0d expected 3", lat); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL hold_err: got %b expected 0", err); end
      sel = 0;
      @(posedge clk); #1;
      n_checks++; if (regs[55:48] !== 8'h66) begin n_fail++; $display("FAIL hold_reg6: got %h expected 66", regs[55:48]); end
   endtask

   task automatic test_reset_mid();
      int lat; logic seen;
      @(negedge clk);
      sel = 1; wr = 0; addr = 4'd8; wdata = 8'h00;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!ready && lat < 20);
      n_checks++; if (rdata !== 8'h81) begin n_fail++; $display("FAIL resp_rd8_rdata: got %h expected 81", rdata); end
      rst_n = 0; #1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 0", ready); end
      n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL async_rst_rdata: got %h expected 00", rdata); end
      sel = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      sel = 1; wr = 1; addr = 4'd4; wdata = 8'hFF;
      @(posedge clk); #1;
      rst_n = 0; #1;
      n_checks++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 8'h00) begin
         n_fail++; $display("FAIL wait_rst_outputs: got %b/%b/%h expected 0/0/00", ready, err, rdata);
      end
      sel = 0;
      @(negedge clk); rst_n = 1;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ready) seen = 1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL wait_rst_no_ready: got %b expected 0", seen); end
      n_checks++; if (regs[39:32] !== 8'h00) begin n_fail++; $display("FAIL wait_rst_reg4: got %h expected 00", regs[39:32]); end
      n_checks++; if (regs[47:40] !== 8'h00) begin n_fail++; $display("FAIL rst_clears_reg5: got %h expected 00", regs[47:40]); end
   endtask

   task automatic test_zero_wait();
      logic [7:0] rd; logic e, ra; int lat;
      access(1, 0, 4'd3, 8'h00, rd, e, lat, ra);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zw_rd3_latency: got %0d expected 1", lat); end
      n_checks++; if (rd !== 8'h00 || e !== 1'b0) begin n_fail++; $display("FAIL zw_rd3: got %h/%b expected 00/0", rd, e); end
      n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL zw_ready_pulse: got %b expected 0", ra); end
      access(1, 1, 4'd5, 8'hA5, rd, e, lat, ra);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zw_wr5_latency: got %0d expected 1", lat); end
      n_checks++; if (regs0[47:40] !== 8'hA5) begin n_fail++; $display("FAIL zw_wr5_reg: got %h expected a5", regs0[47:40]); end
      access(1, 0, 4'd5, 8'h00, rd, e, lat, ra);
      n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL zw_rd5_rdata: got %h expected a5", rd); end
      access(1, 1, 4'd11, 8'h3C, rd, e, lat, ra);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL zw_ro11_err: got %b expected 1", e); end
      n_checks++; if (regs[47:40] !== 8'h00) begin n_fail++; $display("FAIL zw_isolation: got %h expected 00", regs[47:40]); end
   endtask

   initial begin
      test_reset();
      test_read_reset_value();
      test_write_read();
      test_back_to_back();
      test_errors();
      test_hw_collision();
      test_abort();
      test_capture_hold();
      test_reset_mid();
      test_zero_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
